// File: rtl/ram_mbist.sv
// ram_mbist: March C- memory BIST controller for a single-port RAM.
// Optional build macro MBIST_ERR_CAPTURE_EN adds first-mismatch capture registers;
// without it out_err_addr/out_err_expect/out_err_actual are tied to 0.
module ram_mbist #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int ERRCNT_WIDTH = 16
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_start,
  output logic                    out_busy,
  output logic                    out_done,
  output logic                    out_pass,
  output logic [ERRCNT_WIDTH-1:0] out_err_count,
  output logic [ADDR_WIDTH-1:0]   out_err_addr,
  output logic [DATA_WIDTH-1:0]   out_err_expect,
  output logic [DATA_WIDTH-1:0]   out_err_actual,
  output logic [ADDR_WIDTH-1:0]   out_ram_addr,
  output logic                    out_ram_we,
  output logic [DATA_WIDTH-1:0]   out_ram_wdata,
  input  logic [DATA_WIDTH-1:0]   in_ram_rdata
);
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_M0    = 4'd1;
  localparam logic [3:0] S_M1    = 4'd2;
  localparam logic [3:0] S_M2    = 4'd3;
  localparam logic [3:0] S_M3    = 4'd4;
  localparam logic [3:0] S_M4    = 4'd5;
  localparam logic [3:0] S_M5    = 4'd6;
  localparam logic [3:0] S_FLUSH = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] B0 = '0;
  localparam logic [DATA_WIDTH-1:0] B1 = '1;

  logic [3:0]              r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_phase;
  logic                    r_chk;
  logic [DATA_WIDTH-1:0]   r_exp;
  logic [ERRCNT_WIDTH-1:0] r_cnt;
  logic                    r_pass;

  logic                    w_run, w_rw, w_desc, w_read, w_step, w_end, w_start, w_mis;
  logic [DATA_WIDTH-1:0]   w_exp;
  logic [ERRCNT_WIDTH-1:0] w_cnt_next;

  // M1..M4 alternate a read cycle and a write cycle per address; M0 writes only, M5 reads only
  assign w_run   = (r_state >= S_M0) && (r_state <= S_M5);
  assign w_rw    = (r_state >= S_M1) && (r_state <= S_M4);
  assign w_desc  = (r_state == S_M3) || (r_state == S_M4);
  assign w_read  = (w_rw && !r_phase) || (r_state == S_M5);
  assign w_step  = (r_state == S_M0) || (r_state == S_M5) || (w_rw && r_phase);
  assign w_end   = w_desc ? (r_addr == '0) : (r_addr == LAST);
  assign w_start = in_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_exp   = ((r_state == S_M2) || (r_state == S_M4)) ? B1 : B0;
  assign w_mis   = r_chk && (in_ram_rdata != r_exp);
  assign w_cnt_next = (w_mis && !(&r_cnt)) ? r_cnt + ERRCNT_WIDTH'(1) : r_cnt;

  assign out_busy      = (r_state >= S_M0) && (r_state <= S_FLUSH);
  assign out_done      = (r_state == S_DONE);
  assign out_pass      = r_pass;
  assign out_err_count = r_cnt;
  assign out_ram_we    = (r_state == S_M0) || (w_rw && r_phase);
  assign out_ram_addr  = w_run ? r_addr : '0;
  assign out_ram_wdata = (out_ram_we && ((r_state == S_M1) || (r_state == S_M3))) ? B1 : B0;

  // Sequencer: element/address stepping, read-compare pipeline, error count and verdict
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_phase <= 1'b0;
      r_chk   <= 1'b0;
      r_exp   <= '0;
      r_cnt   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_chk   <= w_read;
      r_exp   <= w_exp;
      r_phase <= w_rw ? ~r_phase : 1'b0;
      r_cnt   <= w_start ? '0 : w_cnt_next;
      if (w_start) begin
        r_state <= S_M0;
        r_addr  <= '0;
        r_pass  <= 1'b0;
      end else if (w_step) begin
        r_state <= w_end ? r_state + 4'd1 : r_state;
        r_addr  <= w_end ? (((r_state == S_M2) || (r_state == S_M3)) ? LAST : '0)
                         : (w_desc ? r_addr - ADDR_WIDTH'(1) : r_addr + ADDR_WIDTH'(1));
      end else if (r_state == S_FLUSH) begin
        r_state <= S_DONE;
        r_pass  <= (w_cnt_next == '0);
      end
    end
  end

`ifdef MBIST_ERR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] r_chk_addr;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic [DATA_WIDTH-1:0] r_err_expect;
  logic [DATA_WIDTH-1:0] r_err_actual;

  // Remember which address the in-flight read came from, then latch the first mismatch only
  always_ff @(posedge in_clk) begin
    if (!in_rst || w_start) begin
      r_chk_addr   <= '0;
      r_err_addr   <= '0;
      r_err_expect <= '0;
      r_err_actual <= '0;
    end else begin
      r_chk_addr <= r_addr;
      if (w_mis && (r_cnt == '0)) begin
        r_err_addr   <= r_chk_addr;
        r_err_expect <= r_exp;
        r_err_actual <= in_ram_rdata;
      end
    end
  end

  assign out_err_addr   = r_err_addr;
  assign out_err_expect = r_err_expect;
  assign out_err_actual = r_err_actual;
`else
  assign out_err_addr   = '0;
  assign out_err_expect = '0;
  assign out_err_actual = '0;
`endif
endmodule

// File: tb/tb_ram_mbist.sv
// tb_ram_mbist: randomized self-checking bench for ram_mbist against a faulty behavioural RAM
module tb_ram_mbist;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass, we;
  logic [CW-1:0] cnt;
  logic [AW-1:0] eaddr, raddr;
  logic [DW-1:0] eexp, eact, wdata, rdata;

  logic [DW-1:0] mem [0:7];
  logic [DW-1:0] sa1 [0:7];
  logic [DW-1:0] sa0 [0:7];

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit            we;
    int            a;
    logic [DW-1:0] d;
  } op_t;
  op_t ops[$];
  int            exp_cnt;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_exp, x_act;

  always #5 clk = ~clk;

  ram_mbist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .ERRCNT_WIDTH(CW)) dut (
    .in_clk(clk), .in_rst(rst_n), .in_start(start),
    .out_busy(busy), .out_done(done), .out_pass(pass), .out_err_count(cnt),
    .out_err_addr(eaddr), .out_err_expect(eexp), .out_err_actual(eact),
    .out_ram_addr(raddr), .out_ram_we(we), .out_ram_wdata(wdata), .in_ram_rdata(rdata)
  );

  // Single-port RAM with registered read and per-bit stuck-at faults applied on read
  always @(posedge clk) begin
    if (we) mem[raddr] <= wdata;
    rdata <= (mem[raddr] | sa1[raddr]) & ~sa0[raddr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 8; a++) begin
      sa1[a] = '0;
      sa0[a] = '0;
    end
  endtask

  // Expected operation list from the March C- element table, then replay it on an ideal
  // memory with the current faults to predict mismatches, saturated count and first failure
  task automatic build_model();
    logic [DW-1:0] m [0:D-1];
    logic [DW-1:0] bg;
    logic [DW-1:0] act;
    int errs;
    int a;
    errs = 0;
    ops.delete();
    for (int j = 0; j < D; j++) ops.push_back('{1'b1, j, {DW{1'b0}}});
    for (int e = 1; e <= 4; e++)
      for (int j = 0; j < D; j++) begin
        a  = (e >= 3) ? D - 1 - j : j;
        bg = (e % 2 == 0) ? {DW{1'b1}} : {DW{1'b0}};
        ops.push_back('{1'b0, a, bg});
        ops.push_back('{1'b1, a, ~bg});
      end
    for (int j = 0; j < D; j++) ops.push_back('{1'b0, j, {DW{1'b0}}});
    x_addr = '0;
    x_exp  = '0;
    x_act  = '0;
    foreach (ops[i]) begin
      a = ops[i].a;
      if (ops[i].we) m[a] = ops[i].d;
      else begin
        act = (m[a] | sa1[a]) & ~sa0[a];
        if (act !== ops[i].d) begin
`ifdef MBIST_ERR_CAPTURE_EN
          if (errs == 0) begin
            x_addr = AW'(a);
            x_exp  = ops[i].d;
            x_act  = act;
          end
`endif
          errs++;
        end
      end
    end
    exp_cnt = (errs > (2**CW - 1)) ? 2**CW - 1 : errs;
  endtask

  task automatic chk_idle(string tag);
    chk($sformatf("%s:busy", tag), busy, 0);
    chk($sformatf("%s:done", tag), done, 0);
    chk($sformatf("%s:pass", tag), pass, 0);
    chk($sformatf("%s:we", tag), we, 0);
    chk($sformatf("%s:addr", tag), raddr, 0);
    chk($sformatf("%s:wdata", tag), wdata, 0);
    chk($sformatf("%s:cnt", tag), cnt, 0);
    chk($sformatf("%s:eaddr", tag), eaddr, 0);
    chk($sformatf("%s:eexp", tag), eexp, 0);
    chk($sformatf("%s:eact", tag), eact, 0);
  endtask

  // One full test: start pulse at edge k, port trace for 10*D ops, FLUSH, DONE at edge k+10*D+1
  task automatic run(string tag, int spur);
    build_model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk($sformatf("%s:start_busy", tag), busy, 1);
    chk($sformatf("%s:start_done", tag), done, 0);
    chk($sformatf("%s:start_pass", tag), pass, 0);
    chk($sformatf("%s:start_cnt", tag), cnt, 0);
    chk($sformatf("%s:start_eaddr", tag), eaddr, 0);
    chk($sformatf("%s:start_eexp", tag), eexp, 0);
    chk($sformatf("%s:start_eact", tag), eact, 0);
    for (int i = 0; i < 10*D; i++) begin
      chk($sformatf("%s:op%0d_we", tag, i), we, ops[i].we);
      chk($sformatf("%s:op%0d_addr", tag, i), raddr, ops[i].a);
      if (ops[i].we) chk($sformatf("%s:op%0d_wdata", tag, i), wdata, ops[i].d);
      chk($sformatf("%s:op%0d_busy", tag, i), busy, 1);
      if (i == spur) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk($sformatf("%s:flush_busy", tag), busy, 1);
    chk($sformatf("%s:flush_done", tag), done, 0);
    chk($sformatf("%s:flush_we", tag), we, 0);
    @(posedge clk); #1;
    chk($sformatf("%s:done", tag), done, 1);
    chk($sformatf("%s:busy", tag), busy, 0);
    chk($sformatf("%s:pass", tag), pass, (exp_cnt == 0));
    chk($sformatf("%s:cnt", tag), cnt, exp_cnt);
    chk($sformatf("%s:eaddr", tag), eaddr, x_addr);
    chk($sformatf("%s:eexp", tag), eexp, x_exp);
    chk($sformatf("%s:eact", tag), eact, x_act);
    chk($sformatf("%s:idle_we", tag), we, 0);
    chk($sformatf("%s:idle_addr", tag), raddr, 0);
    @(posedge clk); #1;
    chk($sformatf("%s:hold_done", tag), done, 1);
    chk($sformatf("%s:hold_cnt", tag), cnt, exp_cnt);
  endtask

  initial begin
    int na, nb, nf;
    clear_faults();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("idle");

    run("clean", D + 1);
    chk("clean_pass_const", pass, 1);
    chk("clean_cnt_const", cnt, 0);

    sa1[2] = 8'h01;
    run("sa1_a2b0", D + 3);
    chk("sa1_cnt_const", cnt, 3);
    chk("sa1_pass_const", pass, 0);
`ifdef MBIST_ERR_CAPTURE_EN
    chk("sa1_eaddr_const", eaddr, 2);
    chk("sa1_eexp_const", eexp, 8'h00);
    chk("sa1_eact_const", eact, 8'h01);
`endif

    clear_faults();
    for (int a = 0; a < D; a++) sa0[a] = 8'hFF;
    run("sa0_all", -1);
    chk("sat_cnt_const", cnt, 7);
    chk("sat_pass_const", pass, 0);

    clear_faults();
    run("restart_clean", -1);
    chk("restart_pass_const", pass, 1);
    chk("restart_eaddr_const", eaddr, 0);

    for (int r = 0; r < 6; r++) begin
      clear_faults();
      nf = int'($urandom_range(0, 3));
      for (int f = 0; f < nf; f++) begin
        na = int'($urandom_range(0, D - 1));
        nb = int'($urandom_range(0, DW - 1));
        if ($urandom_range(0, 1) == 1) sa1[na] = sa1[na] | DW'(1 << nb);
        else sa0[na] = sa0[na] | DW'(1 << nb);
      end
      run($sformatf("rand%0d", r), int'($urandom_range(0, 10*D - 1)));
    end

    clear_faults();
    sa1[2] = 8'h01;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3*D + 2; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_busy", busy, 1);
    chk("mid_cnt", cnt, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_idle("mid_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("post_reset");

    clear_faults();
    run("after_reset", -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_mbist.md
# ram_mbist

Parametrised memory built-in self-test (MBIST) controller for the single-port RAM family in the DRAM stage of the design. On request it runs a March C- sequence over a configurable address range and data width, drives the RAM port directly and checks every read against its expected value. It reports pass/fail, a saturating error count and, optionally, the first failing location. It sits between the top-level control and a `SinglePortRAM` instance: the controller owns the RAM port while busy, and the top-level mux returns the port to normal traffic when idle.

## Interface
Parameters:
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 10: RAM address width.
- `DEPTH`, 1024: number of words tested, addresses 0..DEPTH-1; DEPTH ≤ 2^ADDR_WIDTH, DEPTH ≥ 2.
- `ERRCNT_WIDTH`, 16: width of the error counter.

Ports:
- `in_clk` in 1: clock. One clock; reset is synchronous and active-low.
- `in_rst` in 1: synchronous, active-low reset.
- `in_start` in 1: start request; sampled only in IDLE or DONE.
- `out_busy` out 1: test running; the controller owns the RAM port.
- `out_done` out 1: test finished; level, held until the next start or reset.
- `out_pass` out 1: valid while `out_done`=1; 1 means zero mismatches.
- `out_err_count` out ERRCNT_WIDTH: mismatch count, saturating at all-ones.
- `out_err_addr` out ADDR_WIDTH: address of the first mismatch.
- `out_err_expect` out DATA_WIDTH: expected data at the first mismatch.
- `out_err_actual` out DATA_WIDTH: read data at the first mismatch.
- `out_ram_addr` out ADDR_WIDTH: RAM address.
- `out_ram_we` out 1: RAM write enable; 0 means read.
- `out_ram_wdata` out DATA_WIDTH: RAM write data.
- `in_ram_rdata` in DATA_WIDTH: RAM read data, valid the cycle after a read.

## Operation
- States: IDLE → M0 → M1 → M2 → M3 → M4 → M5 → FLUSH → DONE.
- Transition from DONE to M0 on `in_start`=1.
- Reset clears every output to 0 and puts the FSM in IDLE. This includes `out_ram_we`=0 and `out_pass`=0.
- Background patterns: B0 = all zeros, B1 = all ones (DATA_WIDTH bits).

March elements:
- M0, ascending: write B0.
- M1, ascending: read, expect B0; then write B1.
- M2, ascending: read, expect B1; then write B0.
- M3, descending: read, expect B0; then write B1.
- M4, descending: read, expect B1; then write B0.
- M5, ascending: read, expect B0.
- Ascending runs 0..DEPTH-1. Descending runs DEPTH-1..0.
- At the end of an element, the address counter loads the start address of the next element. No idle cycle is inserted between elements.

Checking and error reporting:
- Each read is compared one cycle later against its registered expected value. This includes the final M5 read, which is compared in FLUSH.
- On a mismatch, `out_err_count` increments. It saturates and never wraps.
- Starting from DONE clears the count, the capture registers, `out_pass` and `out_done` on the accepting edge.
- `in_start` while busy is ignored.
- `out_pass` is set on entry to DONE if and only if the count is 0.
- RAM port outputs are combinational from FSM state and address.
- In IDLE and DONE, `out_ram_we`=0 and address/data are 0.

## Timing
- Let edge k be the edge that samples `in_start`=1.
- Cycle k+1 (first op): `out_ram_we`=1, addr 0, wdata B0.
- Element durations in cycles: M0 DEPTH; M1–M4 each 2·DEPTH (read cycle, then write cycle per address); M5 DEPTH.
- Total ops: 10·DEPTH cycles.
- FLUSH: 1 cycle.
- `out_done` is 1 and `out_busy` is 0 after edge k+10·DEPTH+1.
- `out_busy` is 1 from edge k through edge k+10·DEPTH+1 (falls on that edge).
- Compare timing: read issued in cycle c, compared at the edge closing cycle c+1. In M1–M4 that cycle is the write cycle of the same address.
- Reset mid-test: a synchronous abort on the next edge with `in_rst`=0. `out_ram_we`=0 immediately after that edge, and no partial results are kept.

## Configuration
- `MBIST_ERR_CAPTURE_EN` defined: first-mismatch capture registers are built. `out_err_addr`, `out_err_expect` and `out_err_actual` load on the first mismatch only and hold until restart or reset.
- `MBIST_ERR_CAPTURE_EN` undefined: capture registers are omitted and the three ports are tied to 0.
- `out_err_count` and `out_pass` are unaffected by the macro.

## Test plan
- Fault-free behavioural RAM, DEPTH=4, DATA_WIDTH=8, start pulse → `out_done` rises 41 edges after the sampling edge; `out_pass`=1; count 0; address trace is 0,1,2,3 for M0–M2 and M5, and 3,2,1,0 for M3–M4.
- Stuck-at-1 on bit 0 at address 2 → `out_pass`=0; count 3 (the B0 reads in M1, M3 and M5). With the macro: err_addr 2, expect 0x00, actual 0x01.
- All bits stuck-at-0 at every address, DEPTH=4, ERRCNT_WIDTH=2 → count saturates at 3 and does not wrap; `out_pass`=0.
- `in_rst`=0 asserted during M2 → after the next edge: FSM in IDLE, `out_busy`=0, `out_ram_we`=0, `out_done`=0, count 0.
- `in_start` pulsed during M1 → run length unchanged (done at edge k+41).
- Second `in_start` in DONE after a failing run → fresh run on a fault-free RAM reports pass=1 and count 0, with capture registers cleared.
